// File: rtl/segre_pkg.sv
// Shared SEGRE core definitions: instruction-cache geometry defaults and
// the types used by the icache data store.
package segre_pkg;

  localparam int unsigned WORD_SIZE = 32;

  localparam int unsigned ICACHE_WAYS       = 2;
  localparam int unsigned ICACHE_SETS       = 64;
  localparam int unsigned ICACHE_LINE_BYTES = 16;
  localparam int unsigned ICACHE_BEAT_BITS  = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } icache_fill_state_e;

  typedef logic [ICACHE_LINE_BYTES-1:0][7:0] icache_line_t;

endpackage

// File: rtl/segre_icache_way_ram.sv
// One way of the icache data store: beat-wide write port, word-wide
// combinational read port (the parent registers the read).
module segre_icache_way_ram
  import segre_pkg::*;
#(
  parameter  int unsigned SETS       = ICACHE_SETS,
  parameter  int unsigned LINE_BYTES = ICACHE_LINE_BYTES,
  parameter  int unsigned BEAT_BITS  = ICACHE_BEAT_BITS,
  localparam int unsigned BEATS      = LINE_BYTES * 8 / BEAT_BITS,
  localparam int unsigned BEAT_BYTES = BEAT_BITS / 8,
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES),
  localparam int unsigned IDX_W      = $clog2(SETS),
  localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned WOFF_W     = (OFF_W > 2) ? OFF_W - 2 : 1
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     wr_set_i,
  input  logic [BEAT_W-1:0]    wr_beat_i,
  input  logic [BEAT_BITS-1:0] wr_data_i,
  input  logic [IDX_W-1:0]     rd_set_i,
  input  logic [WOFF_W-1:0]    rd_off_i,
  output logic [WORD_SIZE-1:0] rd_data_o
);

  logic [LINE_BYTES-1:0][7:0] mem [SETS];
  logic [OFF_W-1:0]           wr_base;
  logic [OFF_W-1:0]           rd_base;

  // Byte-granular bases keep the little-endian layout identical for
  // the beat writes and the word reads.
  assign wr_base = OFF_W'(int'(wr_beat_i) * BEAT_BYTES);
  assign rd_base = OFF_W'({rd_off_i, 2'b00});

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[wr_set_i][wr_base +: BEAT_BYTES] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[rd_set_i][rd_base +: 4];

endmodule

// File: rtl/segre_icache_data_array.sv
// N-way icache data store: MMU burst line fills plus a one-cycle registered
// instruction-word read port.
module segre_icache_data_array
  import segre_pkg::*;
#(
  parameter  int unsigned WAYS       = ICACHE_WAYS,
  parameter  int unsigned SETS       = ICACHE_SETS,
  parameter  int unsigned LINE_BYTES = ICACHE_LINE_BYTES,
  parameter  int unsigned BEAT_BITS  = ICACHE_BEAT_BITS,
  localparam int unsigned WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 rd_req_i,
  input  logic [WORD_SIZE-1:0] rd_addr_i,
  input  logic [WAY_W-1:0]     rd_way_i,
  output logic                 rd_ready_o,
  output logic                 rd_valid_o,
  output logic [WORD_SIZE-1:0] rd_data_o,
  input  logic                 fill_start_i,
  input  logic [WORD_SIZE-1:0] fill_addr_i,
  input  logic [WAY_W-1:0]     fill_way_i,
  input  logic                 fill_beat_valid_i,
  input  logic [BEAT_BITS-1:0] fill_beat_data_i,
  output logic                 fill_beat_ready_o,
  output logic                 fill_busy_o,
  output logic                 fill_done_o
);

  localparam int unsigned BEATS  = LINE_BYTES * 8 / BEAT_BITS;
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WOFF_W = (OFF_W > 2) ? OFF_W - 2 : 1;

  icache_fill_state_e   state_q;
  logic [BEAT_W-1:0]    beat_cnt_q;
  logic [IDX_W-1:0]     fill_set_q;
  logic [WAY_W-1:0]     fill_way_q;
  logic                 rd_valid_q;
  logic [WORD_SIZE-1:0] rd_data_q;

  logic [IDX_W-1:0]     rd_set;
  logic [WOFF_W-1:0]    rd_off;
  logic                 busy;
  logic [WAYS-1:0]      beat_we;
  logic [WORD_SIZE-1:0] way_rdata [WAYS];

  assign rd_set = IDX_W'(rd_addr_i >> OFF_W);
  assign rd_off = WOFF_W'(rd_addr_i >> 2);
  assign busy   = (state_q == FILL) || (state_q == DONE);

  // Stall only reads that hit the very line under refill; other sets and
  // ways keep streaming alongside the fill.
  assign rd_ready_o = rd_req_i &
                      !(busy && (rd_set == fill_set_q) && (rd_way_i == fill_way_q));

  assign rd_valid_o        = rd_valid_q;
  assign rd_data_o         = rd_data_q;
  assign fill_beat_ready_o = (state_q == FILL);
  assign fill_busy_o       = busy;
  assign fill_done_o       = (state_q == DONE);

  always_comb begin
    beat_we = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      beat_we[w] = (state_q == FILL) && fill_beat_valid_i && (fill_way_q == WAY_W'(w));
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    segre_icache_way_ram #(
      .SETS      (SETS),
      .LINE_BYTES(LINE_BYTES),
      .BEAT_BITS (BEAT_BITS)
    ) u_way_ram (
      .clk_i    (clk_i),
      .we_i     (beat_we[w]),
      .wr_set_i (fill_set_q),
      .wr_beat_i(beat_cnt_q),
      .wr_data_i(fill_beat_data_i),
      .rd_set_i (rd_set),
      .rd_off_i (rd_off),
      .rd_data_o(way_rdata[w])
    );
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      fill_set_q <= '0;
      fill_way_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_ready_o;
      if (rd_ready_o) begin
        rd_data_q <= way_rdata[rd_way_i];
      end
      case (state_q)
        IDLE: begin
          if (fill_start_i) begin
            fill_set_q <= IDX_W'(fill_addr_i >> OFF_W);
            fill_way_q <= fill_way_i;
            beat_cnt_q <= '0;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (fill_beat_valid_i) begin
            if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
              beat_cnt_q <= '0;
              state_q    <= DONE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
